// File: rtl/switch_conditioner_if.sv
// Switch bundle between the board side (master: drives SW_RAW) and the
// conditioner (slave: produces the cleaned vectors and window status).
interface switch_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] SW_RAW;
    logic [WIDTH-1:0] SW_STABLE;
    logic [WIDTH-1:0] SW_RISE;
    logic [WIDTH-1:0] SW_FALL;
    logic             ANY_ON;
    logic [WIDTH-1:0] SW_CAPTURE;
    logic             CAPTURE_VALID;
    logic [1:0]       DBG_STATE;

    // No handshake: SW_RAW is a free-running asynchronous level, and every
    // output is a registered level or one-cycle pulse valid on each CLOCK edge.
    modport master (
        output SW_RAW,
        input  SW_STABLE, SW_RISE, SW_FALL, ANY_ON, SW_CAPTURE, CAPTURE_VALID, DBG_STATE
    );

    modport slave (
        input  SW_RAW,
        output SW_STABLE, SW_RISE, SW_FALL, ANY_ON, SW_CAPTURE, CAPTURE_VALID, DBG_STATE
    );
endinterface

// File: rtl/switch_conditioner.sv
// Synchronise, debounce and edge-detect the board switches, then latch the
// first-flip vector for a bounded window. SWITCH_COND_DEBOUNCE_EN enables debouncing.
module switch_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int WINDOW_CYCLES   = 14000000
) (
    input  logic            CLOCK,
    input  logic            RESET,
    switch_conditioner_if.slave sw
);

    localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_any_on;
    logic [WIDTH-1:0] r_capture;
    logic [WW-1:0]    r_win_cnt;
    state_t           r_state;

    logic [WIDTH-1:0] w_stable_next;
    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_capture_next;
    logic [WW-1:0]    w_win_cnt_next;
    state_t           w_state_next;

`ifdef SWITCH_COND_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
        logic [DW-1:0] r_db_cnt;
        logic          w_accept;

        // A mismatch must persist for the full count; any return to the old level restarts it.
        assign w_accept         = (r_sync2[g] != r_stable[g]) && (r_db_cnt == DB_LAST);
        assign w_stable_next[g] = w_accept ? r_sync2[g] : r_stable[g];

        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                r_db_cnt <= '0;
            end else if ((r_sync2[g] == r_stable[g]) || w_accept) begin
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end
`else
    assign w_stable_next = r_sync2;
`endif

    assign w_rise_next = w_stable_next & ~r_stable;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_any_on <= 1'b0;
        end else begin
            r_sync1  <= sw.SW_RAW;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_rise   <= w_rise_next;
            r_fall   <= ~w_stable_next & r_stable;
            r_any_on <= |w_stable_next;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_capture <= '0;
            r_win_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_capture <= w_capture_next;
            r_win_cnt <= w_win_cnt_next;
        end
    end

    // The window reacts to the stable value being registered this edge, so
    // CAPTURE_VALID rises together with the qualifying SW_RISE.
    always_comb begin
        w_state_next   = r_state;
        w_capture_next = r_capture;
        w_win_cnt_next = r_win_cnt;
        case (r_state)
            S_IDLE: begin
                if ((|w_rise_next) && (r_stable == '0)) begin
                    w_state_next   = S_CAPTURE;
                    w_capture_next = w_stable_next;
                    w_win_cnt_next = '0;
                end
            end
            S_CAPTURE: begin
                if (w_stable_next == '0) begin
                    w_state_next   = S_IDLE;
                    w_capture_next = '0;
                end else if (r_win_cnt == WW'(WINDOW_CYCLES - 1)) begin
                    w_state_next   = S_EXPIRED;
                    w_capture_next = '0;
                end else begin
                    w_win_cnt_next = r_win_cnt + 1'b1;
                    w_capture_next = r_capture | w_rise_next;
                end
            end
            S_EXPIRED: begin
                w_capture_next = '0;
                if (w_stable_next == '0) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next   = S_IDLE;
                w_capture_next = '0;
            end
        endcase
    end

    assign sw.SW_STABLE     = r_stable;
    assign sw.SW_RISE       = r_rise;
    assign sw.SW_FALL       = r_fall;
    assign sw.ANY_ON        = r_any_on;
    assign sw.SW_CAPTURE    = r_capture;
    assign sw.CAPTURE_VALID = (r_state == S_CAPTURE);
    assign sw.DBG_STATE     = r_state;

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input-conditioning stage that sits directly upstream of the jackpot game logic. It synchronises and debounces the four raw board switches and produces one-cycle edge pulses. It also generates a capture window: it latches which switches were turned on first after an all-off state and holds that value for a bounded number of clocks. The game logic therefore sees a clean, first-flip-only switch vector instead of a raw, bouncing level.

## Interface
- WIDTH, 4, number of switch inputs
- DEBOUNCE_CYCLES, 1000000, clocks a synchronised input must hold a new level before it is accepted (≥2)
- WINDOW_CYCLES, 14000000, clocks SW_CAPTURE stays valid after first flip (≥1)
- CLOCK  in  1  system clock
- RESET  in  1  reset RESET, asynchronous, active-high
- SW_RAW  in  WIDTH  raw switch levels, asynchronous to CLOCK
- SW_STABLE  out  WIDTH  debounced switch levels
- SW_RISE  out  WIDTH  one-cycle pulse per bit on stable 0→1
- SW_FALL  out  WIDTH  one-cycle pulse per bit on stable 1→0
- ANY_ON  out  1  OR-reduction of SW_STABLE (registered with it)
- SW_CAPTURE  out  WIDTH  first-flip switch vector, zero outside window
- CAPTURE_VALID  out  1  high while window FSM is in state CAPTURE

## Operation
- Reset: all outputs 0, sync flops 0, debounce counters 0, window counter 0, FSM = IDLE.
- Per bit: two-flop synchroniser (sync1, sync2). The debounce counter clears whenever sync2 == SW_STABLE and increments while they differ. On the edge where the counter == DEBOUNCE_CYCLES-1 and a mismatch still exists, SW_STABLE takes sync2 and the counter clears. Any bounce back to the old level clears the counter; no partial credit.
- SW_RISE/SW_FALL are registered in the same edge as the SW_STABLE update: high for exactly one cycle, never both for one bit.
- Window FSM, evaluated on stable values:
  - IDLE → CAPTURE when any SW_RISE is set and the previous SW_STABLE was all-zero. SW_CAPTURE ← new SW_STABLE and the window counter is loaded to 0.
  - CAPTURE: the counter increments each clock. Further SW_RISE bits are OR-ed into SW_CAPTURE. When the counter == WINDOW_CYCLES-1, go to EXPIRED and clear SW_CAPTURE.
  - EXPIRED: SW_CAPTURE = 0. Stay until SW_STABLE is all-zero.
  - From CAPTURE or EXPIRED: if SW_STABLE becomes all-zero, go to IDLE and clear SW_CAPTURE on that same edge.
- Priority on a simultaneous all-off and window expiry: all-off wins, and the next state is IDLE.
- Re-flipping while in EXPIRED does not reopen the window. All switches must first return off.
- Counter widths: $clog2 of the respective parameter. Counters saturate by construction and never wrap.

## Timing
- With debounce: a raw change that holds steady appears on SW_STABLE and the edge pulse on the (DEBOUNCE_CYCLES+2)th rising edge, counting the edge that first samples it as edge 1.
- Without debounce (macro off): SW_STABLE updates on edge 3.
- SW_CAPTURE and CAPTURE_VALID assert on the same edge as the qualifying SW_RISE. They deassert exactly WINDOW_CYCLES edges later, unless an all-off occurs first.
- Asynchronous RESET mid-window or mid-debounce returns all state to reset values immediately. After release, a switch held on is re-accepted as a fresh 0→1 and opens a new window.

## Configuration
- SWITCH_COND_DEBOUNCE_EN defined: debounce counters are present with the behaviour above.
- Undefined: the counters are removed and SW_STABLE ← sync2 every clock. Edge pulses and the window FSM are unchanged. This mode is used for fast simulation.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, WINDOW_CYCLES=16, macro defined.
- SW_RAW 0000→0010 held → SW_STABLE=0010 and SW_RISE=0010 for 1 cycle on edge 6; SW_CAPTURE=0010 and CAPTURE_VALID=1 for 16 cycles, then SW_CAPTURE=0000 with SW_STABLE still 0010.
- SW_RAW toggles 0↔1 every 2 clocks on bit 0 for 40 clocks → SW_STABLE, SW_RISE and SW_CAPTURE stay 0.
- Bit 2 on, then bit 0 on 5 cycles into the window → SW_CAPTURE goes 0100 then 0101; it expires at the original deadline (16 edges after the first rise).
- In EXPIRED, bit 1 on→off→on with bit 3 held on → no new window, SW_CAPTURE remains 0000.
- Window open with 1000, all switches off so SW_FALL lands on the expiry edge → FSM=IDLE; a new flip of 0001 opens a fresh window with SW_CAPTURE=0001.
- RESET pulsed mid-window with 0100 held → all outputs 0 at once; after release SW_RISE=0100 on edge 6 and a new window opens.
